// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: the LOAD/STORE opcode groups,
// func3 width/sign codes, FSM state encodings, the latched request record and
// a helper that decides whether a func3 code is meaningful for a direction.
// Optional feature macro used by this slice: LSU_TIMEOUT_EN (see lsu.sv).
// -----------------------------------------------------------------------------
package lsu_pkg;

   // Major opcodes of the LOAD and STORE instruction groups
   localparam logic [6:0] INST_TYPE_L = 7'b0000011;
   localparam logic [6:0] INST_TYPE_S = 7'b0100011;

   // Load func3 codes
   localparam logic [2:0] INST_LB  = 3'd0;
   localparam logic [2:0] INST_LH  = 3'd1;
   localparam logic [2:0] INST_LW  = 3'd2;
   localparam logic [2:0] INST_LBU = 3'd4;
   localparam logic [2:0] INST_LHU = 3'd5;

   // Store func3 codes
   localparam logic [2:0] INST_SB  = 3'd0;
   localparam logic [2:0] INST_SH  = 3'd1;
   localparam logic [2:0] INST_SW  = 3'd2;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Fields captured from ex when a request is accepted
   typedef struct packed {
      logic        we;
      logic [2:0]  func3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } ls_req_t;

   // Stores only know byte/half/word; loads additionally have the unsigned forms
   function automatic logic func3_legal(input logic we, input logic [2:0] func3);
      if (we)
         return (func3 == INST_SB) || (func3 == INST_SH) || (func3 == INST_SW);
      else
         return (func3 == INST_LB)  || (func3 == INST_LH) || (func3 == INST_LW) ||
                (func3 == INST_LBU) || (func3 == INST_LHU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   we        in   1 = store, 0 = load
//   func3     in   width/sign code
//   addr      in   low two bits of the byte address
//   wdata     in   raw store data
//   rdata     in   raw bus read word
//   legal     out  func3 is a valid code for this direction
//   aligned   out  access does not straddle its natural boundary
//   wstrb     out  byte strobes (zero for loads)
//   wdata_rep out  store data replicated across all lanes
//   load_data out  selected and sign/zero-extended load result
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  func3,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        legal,
   output logic        aligned,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign legal = func3_legal(we, func3);

   // func3[1:0] encodes the access size for both directions: 0 byte, 1 half, 2 word
   always_comb begin
      aligned   = 1'b1;
      wstrb     = 4'b0000;
      wdata_rep = wdata;
      case (func3[1:0])
         2'd0: begin
            wstrb     = 4'b0001 << addr;
            wdata_rep = {4{wdata[7:0]}};
         end
         2'd1: begin
            aligned   = ~addr[0];
            wstrb     = addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         default: begin
            aligned   = (addr == 2'b00);
            wstrb     = 4'b1111;
         end
      endcase
      if (!we)
         wstrb = 4'b0000;
   end

   // Lane select on the read word, then extension chosen by the load flavour
   always_comb begin
      case (addr)
         2'd0:    rbyte = rdata[7:0];
         2'd1:    rbyte = rdata[15:8];
         2'd2:    rbyte = rdata[23:16];
         default: rbyte = rdata[31:24];
      endcase
      rhalf = addr[1] ? rdata[31:16] : rdata[15:0];
      case (func3)
         INST_LB:  load_data = {{24{rbyte[7]}}, rbyte};
         INST_LH:  load_data = {{16{rhalf[15]}}, rhalf};
         INST_LBU: load_data = {24'h000000, rbyte};
         INST_LHU: load_data = {16'h0000, rhalf};
         default:  load_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit behind the execute stage. Accepts one LOAD/STORE at a time,
// runs it on a single-outstanding req/ack data bus, writes load results to the
// register file and stalls the pipeline while the access is in flight.
// Optional feature: define LSU_TIMEOUT_EN to abort a request that has waited
// TIMEOUT_CYCLES cycles in REQ without an ack (reported on bus_err_o).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ls_*_i                   request from ex (valid, we, func3, addr, wdata, rd)
//   mem_*_o / mem_*_i        data bus request side and slave response
//   rd_addr_o/rd_data_o/rd_wen_o  register file write port
//   hold_flag_o              stall request to ctrl
//   misalign_o, bus_err_o    one-cycle error pulses
// -----------------------------------------------------------------------------
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ls_valid_i,
   input  logic        ls_we_i,
   input  logic [2:0]  ls_func3_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   input  logic [4:0]  ls_rd_addr_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] rd_data_o,
   output logic        rd_wen_o,
   output logic        hold_flag_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   logic [1:0]  state;
   ls_req_t     req_q;
   logic [31:0] load_q;
   logic        misalign_q;

   logic        in_legal;
   logic        in_aligned;
   logic [3:0]  unused_wstrb;
   logic [31:0] unused_wdata;
   logic [31:0] unused_load;

   logic        lat_legal_unused;
   logic        lat_aligned_unused;
   logic [3:0]  lat_wstrb;
   logic [31:0] lat_wdata;
   logic [31:0] lat_load;

   logic        accept;
   logic        reject_misalign;
   logic        timeout_hit;
   logic        expired;
   logic        rd_wen;

   // Front instance only judges the incoming request; its lane outputs are not needed
   lsu_align u_align_in (
      .we        (ls_we_i),
      .func3     (ls_func3_i),
      .addr      (ls_addr_i[1:0]),
      .wdata     (ls_wdata_i),
      .rdata     (mem_rdata_i),
      .legal     (in_legal),
      .aligned   (in_aligned),
      .wstrb     (unused_wstrb),
      .wdata_rep (unused_wdata),
      .load_data (unused_load)
   );

   // Back instance works on the latched fields so bus outputs stay stable in REQ
   lsu_align u_align_lat (
      .we        (req_q.we),
      .func3     (req_q.func3),
      .addr      (req_q.addr[1:0]),
      .wdata     (req_q.wdata),
      .rdata     (mem_rdata_i),
      .legal     (lat_legal_unused),
      .aligned   (lat_aligned_unused),
      .wstrb     (lat_wstrb),
      .wdata_rep (lat_wdata),
      .load_data (lat_load)
   );

   assign accept          = (state == ST_IDLE) & ls_valid_i & in_legal & in_aligned;
   assign reject_misalign = (state == ST_IDLE) & ls_valid_i & in_legal & ~in_aligned;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] req_cnt;
   logic             expired_q;

   assign timeout_hit = (state == ST_REQ) & ~mem_ack_i &
                        (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign expired     = expired_q;

   // Counts REQ cycles without ack; an ack in the expiry cycle takes priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_cnt   <= '0;
         expired_q <= 1'b0;
      end else if (accept) begin
         req_cnt   <= '0;
         expired_q <= 1'b0;
      end else if (timeout_hit) begin
         expired_q <= 1'b1;
      end else if ((state == ST_REQ) && !mem_ack_i) begin
         req_cnt   <= req_cnt + 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg  = (TIMEOUT_CYCLES > 0);
   assign timeout_hit = 1'b0;
   assign expired     = 1'b0;
`endif

   // Main sequencer: latch on accept, wait for ack (or timeout), one DONE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         load_q     <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= reject_misalign;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  req_q.we    <= ls_we_i;
                  req_q.func3 <= ls_func3_i;
                  req_q.addr  <= ls_addr_i;
                  req_q.wdata <= ls_wdata_i;
                  req_q.rd    <= ls_rd_addr_i;
                  state       <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_ack_i) begin
                  load_q <= lat_load;
                  state  <= ST_DONE;
               end else if (timeout_hit) begin
                  state  <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_req_o   = (state == ST_REQ);
   assign mem_we_o    = mem_req_o & req_q.we;
   assign mem_addr_o  = {req_q.addr[31:2], 2'b00};
   assign mem_wdata_o = lat_wdata;
   assign mem_wstrb_o = mem_req_o ? lat_wstrb : 4'b0000;

   // x0 loads still touch the bus but never write back
   assign rd_wen      = (state == ST_DONE) & ~req_q.we & (req_q.rd != 5'd0) & ~expired;
   assign rd_wen_o    = rd_wen;
   assign rd_addr_o   = rd_wen ? req_q.rd : 5'd0;
   assign rd_data_o   = rd_wen ? load_q : 32'd0;

   assign hold_flag_o = accept | (state == ST_REQ);
   assign misalign_o  = misalign_q;
   assign bus_err_o   = (state == ST_DONE) & expired;

endmodule
